l2todr_req_arb: RTL and testbench

- Sits inside the l2cache, between the L2 pipeline, the L2TLB and the directory port.
- Merges the L2 and L2TLB request streams into the single shared l2todr_req channel using round-robin arbitration.
- Steers directory snack responses back to the L2 or the L2TLB by nodeid parity: even nodeid goes to L2, odd nodeid goes to L2TLB.
- All channels use valid/retry handshakes. A transfer happens in a cycle where valid=1 and retry=0.

---
 rtl/l2todr_req_arb.sv | 164 ++++++++++++++++
 tb/tb_l2todr_req_arb.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2todr_req_arb.sv
// Merges L2 and L2TLB requests onto the shared directory request channel and
// routes directory snacks back by nodeid parity. Define L2TLB_PRIO_EN for fixed L2TLB priority.
module l2todr_req_arb #(
    parameter int REQ_W         = 64,
    parameter int SNACK_W       = 64,
    parameter int SNACK_NID_LSB = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               l2_req_valid,
    output logic               l2_req_retry,
    input  logic [REQ_W-1:0]   l2_req,
    input  logic               l2tlb_req_valid,
    output logic               l2tlb_req_retry,
    input  logic [REQ_W-1:0]   l2tlb_req,
    output logic               l2todr_req_valid,
    input  logic               l2todr_req_retry,
    output logic [REQ_W-1:0]   l2todr_req,
    input  logic               drtol2_snack_valid,
    output logic               drtol2_snack_retry,
    input  logic [SNACK_W-1:0] drtol2_snack,
    output logic               l2_snack_valid,
    input  logic               l2_snack_retry,
    output logic [SNACK_W-1:0] l2_snack,
    output logic               l2tlb_snack_valid,
    input  logic               l2tlb_snack_retry,
    output logic [SNACK_W-1:0] l2tlb_snack
);

    // Source index 0 is L2, 1 is L2TLB.
    logic [REQ_W-1:0] fifo_mem [2][2];
    logic [1:0]       fifo_cnt [2];
    logic             fifo_wp  [2];
    logic             fifo_rp  [2];
    logic [REQ_W-1:0] src_req  [2];
    logic [REQ_W-1:0] head     [2];
    logic [1:0]       src_vld;
    logic [1:0]       full;
    logic [1:0]       nempty;
    logic [1:0]       push;
    logic [1:0]       pop;

    logic             out_load;
    logic             grant;
    logic             grant_sel;

    logic             req_vld_p1;
    logic [REQ_W-1:0] req_p1;

    logic               snk_vld_p0;
    logic               snk_dst_p0;
    logic [SNACK_W-1:0] snk_p0;
    logic               snk_dst_retry;
    logic               snk_load;

    assign src_vld = {l2tlb_req_valid, l2_req_valid};

    always_comb begin
        src_req[0] = l2_req;
        src_req[1] = l2tlb_req;
        full       = '0;
        nempty     = '0;
        push       = '0;
        for (int s = 0; s < 2; s++) begin
            head[s]   = fifo_mem[s][fifo_rp[s]];
            full[s]   = (fifo_cnt[s] == 2'd2);
            nempty[s] = (fifo_cnt[s] != 2'd0);
            push[s]   = src_vld[s] && !full[s];
        end
    end

    // Retry comes from occupancy alone so it never depends on the downstream retry.
    assign l2_req_retry    = full[0];
    assign l2tlb_req_retry = full[1];

    // ---- stage p0: per-source input FIFOs ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < 2; s++) begin
                fifo_cnt[s] <= 2'd0;
                fifo_wp[s]  <= 1'b0;
                fifo_rp[s]  <= 1'b0;
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (push[s]) fifo_wp[s] <= ~fifo_wp[s];
                if (pop[s])  fifo_rp[s] <= ~fifo_rp[s];
                fifo_cnt[s] <= fifo_cnt[s] + {1'b0, push[s]} - {1'b0, pop[s]};
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (push[s]) fifo_mem[s][fifo_wp[s]] <= src_req[s];
        end
    end

`ifdef L2TLB_PRIO_EN
    always_comb begin
        out_load  = !req_vld_p1 || !l2todr_req_retry;
        grant_sel = nempty[1];
        grant     = out_load && (nempty != 2'b00);
    end
`else
    logic last_grant;

    always_comb begin
        out_load  = !req_vld_p1 || !l2todr_req_retry;
        grant_sel = nempty[1];
        if (nempty == 2'b11) grant_sel = ~last_grant;
        grant     = out_load && (nempty != 2'b00);
    end

    // Reset to L2TLB so the first tie is won by L2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      last_grant <= 1'b1;
        else if (grant) last_grant <= grant_sel;
    end
`endif

    assign pop[0] = grant && !grant_sel;
    assign pop[1] = grant &&  grant_sel;

    // ---- stage p1: output register toward the directory ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_vld_p1 <= 1'b0;
            req_p1     <= '0;
        end else if (out_load) begin
            req_vld_p1 <= grant;
            if (grant) req_p1 <= head[grant_sel];
        end
    end

    assign l2todr_req_valid = req_vld_p1;
    assign l2todr_req       = req_p1;

    // Only the selected destination's retry can stall the slot.
    assign snk_dst_retry      = snk_dst_p0 ? l2tlb_snack_retry : l2_snack_retry;
    assign drtol2_snack_retry = snk_vld_p0 && snk_dst_retry;
    assign snk_load           = !snk_vld_p0 || !snk_dst_retry;

    // ---- stage p0: snack route register ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snk_vld_p0 <= 1'b0;
            snk_dst_p0 <= 1'b0;
            snk_p0     <= '0;
        end else if (snk_load) begin
            snk_vld_p0 <= drtol2_snack_valid;
            if (drtol2_snack_valid) begin
                snk_p0     <= drtol2_snack;
                snk_dst_p0 <= drtol2_snack[SNACK_NID_LSB];
            end
        end
    end

    assign l2_snack_valid    = snk_vld_p0 && !snk_dst_p0;
    assign l2tlb_snack_valid = snk_vld_p0 &&  snk_dst_p0;
    assign l2_snack          = snk_p0;
    assign l2tlb_snack       = snk_p0;

endmodule

// File: tb/tb_l2todr_req_arb.sv
// Directed + randomized bench for l2todr_req_arb with per-stream scoreboards.
module tb_l2todr_req_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        l2_req_valid, l2_req_retry;
    logic [63:0] l2_req;
    logic        l2tlb_req_valid, l2tlb_req_retry;
    logic [63:0] l2tlb_req;
    logic        l2todr_req_valid, l2todr_req_retry;
    logic [63:0] l2todr_req;
    logic        drtol2_snack_valid, drtol2_snack_retry;
    logic [63:0] drtol2_snack;
    logic        l2_snack_valid, l2_snack_retry;
    logic [63:0] l2_snack;
    logic        l2tlb_snack_valid, l2tlb_snack_retry;
    logic [63:0] l2tlb_snack;

    always #5 clk = ~clk;

    l2todr_req_arb dut (
        .clk                (clk),
        .reset              (reset),
        .l2_req_valid       (l2_req_valid),
        .l2_req_retry       (l2_req_retry),
        .l2_req             (l2_req),
        .l2tlb_req_valid    (l2tlb_req_valid),
        .l2tlb_req_retry    (l2tlb_req_retry),
        .l2tlb_req          (l2tlb_req),
        .l2todr_req_valid   (l2todr_req_valid),
        .l2todr_req_retry   (l2todr_req_retry),
        .l2todr_req         (l2todr_req),
        .drtol2_snack_valid (drtol2_snack_valid),
        .drtol2_snack_retry (drtol2_snack_retry),
        .drtol2_snack       (drtol2_snack),
        .l2_snack_valid     (l2_snack_valid),
        .l2_snack_retry     (l2_snack_retry),
        .l2_snack           (l2_snack),
        .l2tlb_snack_valid  (l2tlb_snack_valid),
        .l2tlb_snack_retry  (l2tlb_snack_retry),
        .l2tlb_snack        (l2tlb_snack)
    );

    int n_vec = 0;
    int n_err = 0;

    // Pending stimulus per source, and expected outputs per stream.
    logic [63:0] src_l2[$], src_tlb[$], src_snk[$];
    logic [63:0] q_l2[$], q_tlb[$], q_l2s[$], q_tlbs[$];
    logic [63:0] out_log[$];
    bit          src_of [bit [63:0]];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int busy();
        return src_l2.size() + src_tlb.size() + src_snk.size() +
               q_l2.size() + q_tlb.size() + q_l2s.size() + q_tlbs.size();
    endfunction

    task automatic drive();
        l2_req_valid       = (src_l2.size() != 0);
        l2_req             = (src_l2.size() != 0) ? src_l2[0] : 64'd0;
        l2tlb_req_valid    = (src_tlb.size() != 0);
        l2tlb_req          = (src_tlb.size() != 0) ? src_tlb[0] : 64'd0;
        drtol2_snack_valid = (src_snk.size() != 0);
        drtol2_snack       = (src_snk.size() != 0) ? src_snk[0] : 64'd0;
    endtask

    task automatic clear_all();
        src_l2.delete(); src_tlb.delete(); src_snk.delete();
        q_l2.delete(); q_tlb.delete(); q_l2s.delete(); q_tlbs.delete();
        src_of.delete();
    endtask

    // One clock: record handshakes at negedge, then advance stimulus after posedge.
    task automatic tick();
        logic [63:0] p;
        @(negedge clk);
        if (l2_req_valid && !l2_req_retry) begin
            p = src_l2.pop_front(); q_l2.push_back(p); src_of[p] = 1'b0;
        end
        if (l2tlb_req_valid && !l2tlb_req_retry) begin
            p = src_tlb.pop_front(); q_tlb.push_back(p); src_of[p] = 1'b1;
        end
        if (drtol2_snack_valid && !drtol2_snack_retry) begin
            p = src_snk.pop_front();
            if (p[0]) q_tlbs.push_back(p);
            else      q_l2s.push_back(p);
        end
        if (l2todr_req_valid && !l2todr_req_retry) begin
            p = l2todr_req;
            out_log.push_back(p);
            chk("req_known", 64'(src_of.exists(p)), 64'd1);
            if (src_of.exists(p)) begin
                if (src_of[p]) chk("req_tlb_order", p, q_tlb.pop_front());
                else           chk("req_l2_order", p, q_l2.pop_front());
                src_of.delete(p);
            end
        end
        if (l2_snack_valid || l2tlb_snack_valid)
            chk("snack_onehot", 64'(l2_snack_valid && l2tlb_snack_valid), 64'd0);
        if (l2_snack_valid && !l2_snack_retry) begin
            if (q_l2s.size() != 0) chk("l2_snack", l2_snack, q_l2s.pop_front());
            else                   chk("l2_snack_spurious", 64'(l2_snack_valid), 64'd0);
        end
        if (l2tlb_snack_valid && !l2tlb_snack_retry) begin
            if (q_tlbs.size() != 0) chk("l2tlb_snack", l2tlb_snack, q_tlbs.pop_front());
            else                    chk("l2tlb_snack_spurious", 64'(l2tlb_snack_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic drain(input int max_cyc, input string tag);
        for (int i = 0; i < max_cyc && busy() != 0; i++) tick();
        chk(tag, 64'(busy()), 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_all();
        drive();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic [63:0] exp2 [8];

    initial begin
        reset             = 1'b1;
        l2todr_req_retry  = 1'b0;
        l2_snack_retry    = 1'b0;
        l2tlb_snack_retry = 1'b0;
        clear_all();
        drive();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_valid",   64'(l2todr_req_valid), 64'd0);
        chk("rst_req",         l2todr_req,            64'd0);
        chk("rst_l2_retry",    64'(l2_req_retry),     64'd0);
        chk("rst_tlb_retry",   64'(l2tlb_req_retry),  64'd0);
        chk("rst_snk_retry",   64'(drtol2_snack_retry), 64'd0);
        chk("rst_l2s_valid",   64'(l2_snack_valid),   64'd0);
        chk("rst_tlbs_valid",  64'(l2tlb_snack_valid), 64'd0);
        chk("rst_l2s",         l2_snack,              64'd0);
        chk("rst_tlbs",        l2tlb_snack,           64'd0);
        reset = 1'b0;
        tick();

        // Single request latency
        out_log.delete();
        src_l2.push_back(64'hA5);
        drive();
        tick();
        chk("lat_c1_valid", 64'(l2todr_req_valid), 64'd0);
        tick();
        chk("lat_c2_valid", 64'(l2todr_req_valid), 64'd1);
        chk("lat_c2_req",   l2todr_req,            64'hA5);
        chk("lat_tlb_idle", 64'(l2tlb_req_retry),  64'd0);
        tick();
        chk("lat_count", 64'(out_log.size()), 64'd1);

        // Both sources backlogged
        do_reset();
        out_log.delete();
        for (int i = 0; i < 4; i++) begin
            src_l2.push_back(64'(2 * i + 1));
            src_tlb.push_back(64'(2 * i + 2));
        end
        drive();
        drain(40, "rr_drain");
`ifdef L2TLB_PRIO_EN
        exp2 = '{64'h2, 64'h4, 64'h6, 64'h8, 64'h1, 64'h3, 64'h5, 64'h7};
`else
        exp2 = '{64'h1, 64'h2, 64'h3, 64'h4, 64'h5, 64'h6, 64'h7, 64'h8};
`endif
        chk("rr_count", 64'(out_log.size()), 64'd8);
        for (int i = 0; i < 8 && i < out_log.size(); i++) chk("rr_order", out_log[i], exp2[i]);

        // Downstream backpressure
        out_log.delete();
        l2todr_req_retry = 1'b1;
        src_l2.push_back(64'h100);
        src_l2.push_back(64'h101);
        src_l2.push_back(64'h102);
        drive();
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k >= 3) begin
                chk("bp_l2_retry", 64'(l2_req_retry),     64'd1);
                chk("bp_valid",    64'(l2todr_req_valid), 64'd1);
                chk("bp_hold",     l2todr_req,            64'h100);
            end
        end
        l2todr_req_retry = 1'b0;
        drain(20, "bp_drain");
        chk("bp_count", 64'(out_log.size()), 64'd3);
        for (int i = 0; i < 3 && i < out_log.size(); i++) chk("bp_order", out_log[i], 64'(64'h100 + i));

        // Snack routing
        src_snk.push_back(64'h10);
        src_snk.push_back(64'h11);
        drive();
        tick();
        chk("snk_l2_valid",  64'(l2_snack_valid),    64'd1);
        chk("snk_l2_data",   l2_snack,               64'h10);
        chk("snk_tlb_idle",  64'(l2tlb_snack_valid), 64'd0);
        tick();
        chk("snk_tlb_valid", 64'(l2tlb_snack_valid), 64'd1);
        chk("snk_tlb_data",  l2tlb_snack,            64'h11);
        chk("snk_l2_idle",   64'(l2_snack_valid),    64'd0);
        tick();

        l2_snack_retry = 1'b1;
        src_snk.push_back(64'h20);
        src_snk.push_back(64'h23);
        drive();
        tick();
        repeat (3) begin
            chk("stall_l2_valid", 64'(l2_snack_valid),     64'd1);
            chk("stall_l2_data",  l2_snack,                64'h20);
            chk("stall_retry",    64'(drtol2_snack_retry), 64'd1);
            tick();
        end
        l2_snack_retry = 1'b0;
        drain(10, "stall_drain");

        l2tlb_snack_retry = 1'b1;
        src_snk.push_back(64'h30);
        drive();
        tick();
        chk("other_retry_valid", 64'(l2_snack_valid),     64'd1);
        chk("other_retry_data",  l2_snack,                64'h30);
        chk("other_retry_none",  64'(drtol2_snack_retry), 64'd0);
        l2tlb_snack_retry = 1'b0;
        drain(10, "other_drain");

        // Reset with requests in flight
        out_log.delete();
        src_l2.push_back(64'h200);
        src_l2.push_back(64'h201);
        drive();
        tick();
        tick();
        reset = 1'b1;
        clear_all();
        drive();
        #1;
        chk("midrst_valid", 64'(l2todr_req_valid), 64'd0);
        chk("midrst_retry", 64'(l2_req_retry),     64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (6) tick();
        chk("midrst_nothing", 64'(out_log.size()), 64'd0);

        // Concurrent traffic with random retries
        for (int i = 0; i < 20; i++) begin
            src_l2.push_back(64'(64'h1000 + i));
            src_tlb.push_back(64'(64'h2000 + i));
            src_snk.push_back(64'(64'h3000 + 2 * i + $urandom_range(0, 1)));
        end
        drive();
        for (int c = 0; c < 600 && busy() != 0; c++) begin
            l2todr_req_retry  = ($urandom_range(0, 3) == 0);
            l2_snack_retry    = ($urandom_range(0, 3) == 0);
            l2tlb_snack_retry = ($urandom_range(0, 3) == 0);
            tick();
        end
        l2todr_req_retry  = 1'b0;
        l2_snack_retry    = 1'b0;
        l2tlb_snack_retry = 1'b0;
        drain(50, "rand_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
